// File: rtl/mem_checker_pkg.sv
// Shared types and default parameters for the memory read-back checker.
// Holds the checker FSM state encoding and the default sizing constants.
// Optional magnitude compare is controlled by macro MEM_CHECKER_LESS_EN.
package mem_checker_pkg;

  localparam int MC_WIDTH        = 8;
  localparam int MC_LANES        = 4;
  localparam int MC_ADDR_W       = 16;
  localparam int MC_CNT_W        = 16;
  localparam int MC_STOP_ON_FAIL = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/mem_checker_cmp_lane.sv
// Per-lane comparator: mismatch, data-less-than-expected and zero flags.
// Purely combinational, zero latency; no flow control.
// Magnitude compare only built with macro MEM_CHECKER_LESS_EN defined.
module cmp_lane #(
  parameter int p_WIDTH = 8
) (
  input  logic [p_WIDTH-1:0] data,
  input  logic [p_WIDTH-1:0] exp_lane,
  input  logic               en,
  output logic               ne,
  output logic               lt,
  output logic               zero
);

  // A disabled lane never mismatches and never blocks the all-zero flag.
  assign ne   = en && (data != exp_lane);
  assign zero = !en || (data == '0);

`ifdef MEM_CHECKER_LESS_EN
  assign lt = en && (data < exp_lane);
`else
  assign lt = 1'b0;
`endif

endmodule

// File: rtl/mem_checker.sv
// Memory read-back checker: compares beats lane-wise, counts bad beats, logs first bad address.
// Results are registered one cycle after an accepted beat; o_VALID pulses once per beat.
// No backpressure: beats are accepted only in RUN without a coincident start. Macro MEM_CHECKER_LESS_EN enables o_LESS.
module mem_checker
  import mem_checker_pkg::*;
#(
  parameter int p_WIDTH        = MC_WIDTH,
  parameter int p_LANES        = MC_LANES,
  parameter int p_ADDR_W       = MC_ADDR_W,
  parameter int p_CNT_W        = MC_CNT_W,
  parameter int p_STOP_ON_FAIL = MC_STOP_ON_FAIL
) (
  input  logic                       i_CLK,
  input  logic                       i_RST,
  input  logic                       i_START,
  input  logic                       i_VALID,
  input  logic                       i_LAST,
  input  logic [p_ADDR_W-1:0]        i_ADDR,
  input  logic [p_WIDTH*p_LANES-1:0] i_DATA,
  input  logic [p_WIDTH*p_LANES-1:0] i_EXP,
  input  logic [p_LANES-1:0]         i_MASK,
  output logic                       o_VALID,
  output logic [p_LANES-1:0]         o_LANE_ERR,
  output logic [p_LANES-1:0]         o_LESS,
  output logic                       o_ZERO,
  output logic [p_CNT_W-1:0]         o_ERR_CNT,
  output logic [p_ADDR_W-1:0]        o_FIRST_ADDR,
  output logic                       o_FIRST_VALID,
  output logic                       o_BUSY,
  output logic                       o_DONE,
  output logic                       o_HALT
);

  localparam logic [p_CNT_W-1:0] CNT_ONE = 1;

  state_t             state;
  state_t             state_nxt;
  logic [p_LANES-1:0] lane_ne;
  logic [p_LANES-1:0] lane_lt;
  logic [p_LANES-1:0] lane_z;
  logic               accept;
  logic               mismatch;

  for (genvar k = 0; k < p_LANES; k++) begin : g_lane
    cmp_lane #(.p_WIDTH(p_WIDTH)) u_cmp_lane (
      .data     (i_DATA[k*p_WIDTH +: p_WIDTH]),
      .exp_lane (i_EXP[k*p_WIDTH +: p_WIDTH]),
      .en       (i_MASK[k]),
      .ne       (lane_ne[k]),
      .lt       (lane_lt[k]),
      .zero     (lane_z[k])
    );
  end

  // Start always wins over a same-cycle beat, so the beat is dropped.
  assign accept   = (state == ST_RUN) && i_VALID && !i_START;
  assign mismatch = |lane_ne;

  // Next-state: start restarts from anywhere; a failing beat outranks last.
  always_comb begin
    state_nxt = state;
    if (i_START) begin
      state_nxt = ST_RUN;
    end else if (accept) begin
      if (mismatch && (p_STOP_ON_FAIL != 0)) begin
        state_nxt = ST_HALT;
      end else if (i_LAST) begin
        state_nxt = ST_DONE;
      end
    end
  end

  // State register; reset overrides start.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Result and statistics registers; reset also kills any pending result pulse.
  always_ff @(posedge i_CLK) begin
    if (i_RST || i_START) begin
      o_VALID       <= 1'b0;
      o_LANE_ERR    <= '0;
      o_LESS        <= '0;
      o_ZERO        <= 1'b0;
      o_ERR_CNT     <= '0;
      o_FIRST_ADDR  <= '0;
      o_FIRST_VALID <= 1'b0;
    end else begin
      o_VALID <= accept;
      if (accept) begin
        o_LANE_ERR <= lane_ne;
        o_LESS     <= lane_lt;
        o_ZERO     <= &lane_z;
        if (mismatch) begin
          if (o_ERR_CNT != '1) begin
            o_ERR_CNT <= o_ERR_CNT + CNT_ONE;
          end
          if (!o_FIRST_VALID) begin
            o_FIRST_ADDR  <= i_ADDR;
            o_FIRST_VALID <= 1'b1;
          end
        end
      end
    end
  end

  assign o_BUSY = (state == ST_RUN);
  assign o_DONE = (state == ST_DONE);
  assign o_HALT = (state == ST_HALT);

endmodule

// File: tb/tb_mem_checker.sv
// Directed bench for mem_checker: default, stop-on-fail and 2-bit-counter instances share stimulus.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected o_LESS follows macro MEM_CHECKER_LESS_EN.
module tb_mem_checker;

  logic        clk = 1'b0;
  logic        rst, start, valid, last;
  logic [15:0] addr;
  logic [31:0] data, expd;
  logic [3:0]  mask;

  logic        a_valid, a_zero, a_fv, a_busy, a_done, a_halt;
  logic [3:0]  a_lerr, a_less;
  logic [15:0] a_err, a_fa;
  logic        s_valid, s_zero, s_fv, s_busy, s_done, s_halt;
  logic [3:0]  s_lerr, s_less;
  logic [15:0] s_err, s_fa;
  logic        c_valid, c_zero, c_fv, c_busy, c_done, c_halt;
  logic [3:0]  c_lerr, c_less;
  logic [1:0]  c_err;
  logic [15:0] c_fa;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_checker u_dut (
    .i_CLK(clk), .i_RST(rst), .i_START(start), .i_VALID(valid), .i_LAST(last),
    .i_ADDR(addr), .i_DATA(data), .i_EXP(expd), .i_MASK(mask),
    .o_VALID(a_valid), .o_LANE_ERR(a_lerr), .o_LESS(a_less), .o_ZERO(a_zero),
    .o_ERR_CNT(a_err), .o_FIRST_ADDR(a_fa), .o_FIRST_VALID(a_fv),
    .o_BUSY(a_busy), .o_DONE(a_done), .o_HALT(a_halt)
  );

  mem_checker #(.p_STOP_ON_FAIL(1)) u_dut_stop (
    .i_CLK(clk), .i_RST(rst), .i_START(start), .i_VALID(valid), .i_LAST(last),
    .i_ADDR(addr), .i_DATA(data), .i_EXP(expd), .i_MASK(mask),
    .o_VALID(s_valid), .o_LANE_ERR(s_lerr), .o_LESS(s_less), .o_ZERO(s_zero),
    .o_ERR_CNT(s_err), .o_FIRST_ADDR(s_fa), .o_FIRST_VALID(s_fv),
    .o_BUSY(s_busy), .o_DONE(s_done), .o_HALT(s_halt)
  );

  mem_checker #(.p_CNT_W(2)) u_dut_cnt2 (
    .i_CLK(clk), .i_RST(rst), .i_START(start), .i_VALID(valid), .i_LAST(last),
    .i_ADDR(addr), .i_DATA(data), .i_EXP(expd), .i_MASK(mask),
    .o_VALID(c_valid), .o_LANE_ERR(c_lerr), .o_LESS(c_less), .o_ZERO(c_zero),
    .o_ERR_CNT(c_err), .o_FIRST_ADDR(c_fa), .o_FIRST_VALID(c_fv),
    .o_BUSY(c_busy), .o_DONE(c_done), .o_HALT(c_halt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat (or idle when v=0) and advance one edge.
  task automatic beat(input logic v, input logic l, input logic [15:0] a,
                      input logic [31:0] d, input logic [31:0] e, input logic [3:0] m);
    valid = v; last = l; addr = a; data = d; expd = e; mask = m;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1; valid = 1'b0; last = 1'b0;
    tick();
    start = 1'b0;
  endtask

  logic [3:0] less_exp;

  initial begin
`ifdef MEM_CHECKER_LESS_EN
    less_exp = 4'b0001;
`else
    less_exp = 4'b0000;
`endif
    rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0;
    addr = '0; data = '0; expd = '0; mask = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid", a_valid, 0);
    check("rst_zero", a_zero, 0);
    check("rst_err", a_err, 0);
    check("rst_fv", a_fv, 0);
    check("rst_state", {a_busy, a_done, a_halt}, 0);

    // Clean run of four matching beats
    do_start();
    check("run_busy", a_busy, 1);
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, (i == 3), 16'(i), 32'h01020304, 32'h01020304, 4'hF);
      check($sformatf("match_vld%0d", i), a_valid, 1);
    end
    check("match_done", a_done, 1);
    beat(1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 4'h0);
    check("match_vld_end", a_valid, 0);
    check("match_err", a_err, 0);
    check("match_fv", a_fv, 0);
    check("match_lerr", a_lerr, 0);

    // Beat while DONE is ignored
    beat(1'b1, 1'b0, 16'h5, 32'hFFFFFFFF, 32'h0, 4'hF);
    check("done_ignore_vld", a_valid, 0);
    check("done_ignore_err", a_err, 0);

    // Lane-2 mismatch, then masked, zero-mask and magnitude beats
    do_start();
    beat(1'b1, 1'b0, 16'h0010, 32'h01AA0304, 32'h01020304, 4'hF);
    check("mm_lerr", a_lerr, 4'b0100);
    check("mm_err", a_err, 1);
    check("mm_faddr", a_fa, 16'h0010);
    check("mm_fv", a_fv, 1);
    check("mm_less", a_less, 0);
    check("stop_halt1", s_halt, 1);
    beat(1'b1, 1'b0, 16'h0020, 32'h01AA0304, 32'h01020304, 4'hB);
    check("mask_vld", a_valid, 1);
    check("mask_lerr", a_lerr, 0);
    check("mask_err", a_err, 1);
    check("mask_faddr", a_fa, 16'h0010);
    check("halt_no_vld", s_valid, 0);
    beat(1'b1, 1'b0, 16'h0030, 32'h01AA0304, 32'h01020304, 4'h0);
    check("mask0_zero", a_zero, 1);
    check("mask0_err", a_err, 1);
    beat(1'b1, 1'b0, 16'h0040, 32'h01020305, 32'h01020307, 4'hF);
    check("less_lerr", a_lerr, 4'b0001);
    check("less_val", a_less, less_exp);
    check("less_err", a_err, 2);
    check("less_zero", a_zero, 0);
    beat(1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 4'h0);
    check("hold_vld", a_valid, 0);
    check("hold_lerr", a_lerr, 4'b0001);
    check("hold_less", a_less, less_exp);

    // Stop on fail: beat 2 of 5 mismatches
    do_start();
    check("stop_restart_halt", s_halt, 0);
    check("stop_restart_busy", s_busy, 1);
    check("restart_err_clr", a_err, 0);
    check("restart_lerr_clr", a_lerr, 0);
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, (i == 4), 16'(16'h100 + i),
           (i == 1) ? 32'h11223345 : 32'h11223344, 32'h11223344, 4'hF);
      if (i == 1) begin
        check("stop_vld_b2", s_valid, 1);
        check("stop_halt_b2", s_halt, 1);
      end else if (i > 1) begin
        check($sformatf("stop_novld_b%0d", i + 1), s_valid, 0);
      end
    end
    check("stop_err", s_err, 1);
    check("stop_halt_end", s_halt, 1);
    check("nostop_done", a_done, 1);
    check("nostop_err", a_err, 1);
    check("nostop_faddr", a_fa, 16'h0101);

    // Counter saturation with a 2-bit counter
    do_start();
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, (i == 4), 16'h200, 32'hFFFFFFFF, 32'h00000000, 4'hF);
      if (i == 2) check("sat_cnt3", c_err, 2'd3);
    end
    check("sat_cnt_end", c_err, 2'd3);
    check("sat_done", c_done, 1);
    check("wide_cnt", a_err, 5);
    check("stop_cnt", s_err, 1);

    // Start racing a mismatching beat
    do_start();
    start = 1'b1;
    beat(1'b1, 1'b0, 16'h300, 32'hFFFFFFFF, 32'h0, 4'hF);
    start = 1'b0;
    check("race_start_vld", a_valid, 0);
    check("race_start_err", a_err, 0);
    check("race_start_busy", a_busy, 1);
    beat(1'b1, 1'b0, 16'h301, 32'hFFFFFFFF, 32'h0, 4'hF);
    check("race_accept_vld", a_valid, 1);
    check("race_accept_err", a_err, 1);

    // Reset racing an in-flight beat
    rst = 1'b1;
    beat(1'b1, 1'b0, 16'h302, 32'hFFFFFFFF, 32'h0, 4'hF);
    check("race_rst_vld", a_valid, 0);
    check("race_rst_err", a_err, 0);
    check("race_rst_fv", a_fv, 0);
    check("race_rst_fa", a_fa, 0);
    check("race_rst_lerr", a_lerr, 0);
    check("race_rst_zero", a_zero, 0);
    check("race_rst_state", {a_busy, a_done, a_halt}, 0);
    start = 1'b1;
    beat(1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 4'h0);
    check("rst_over_start", a_busy, 0);
    rst = 1'b0; start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
